hv_stream_gen: RTL and testbench
================================

Name: hv_stream_gen

Overview:
- Produces the per-element hypervector stream consumed by the HDC encode/train/infer core.
- Accepts raw quantized features over valid/ready and emits one level hypervector (im_value) and one position hypervector (im_pos) per feature.
- Tags the final element of each sample (hv_last) and counts completed samples.
- Sits between the feature source (DMA/testbench FIFO) and the encoder core, upstream of its bind/bundle logic.

Parameters:
- DIM, 256, hypervector width in bits; must be divisible by 2*2^LVL_DW.
- LVL_DW, 4, level index width; LEVELS = 2^LVL_DW.
- SMP_SIZE, 64, features per sample.
- ELEM_DW, 6, width of the element index; must satisfy 2^ELEM_DW >= SMP_SIZE.
- SMP_CNT_DW, 16, width of the completed-sample counter.
- SEED_POS, DIM'h…A5A5 repeated, base position hypervector.
- SEED_LVL, DIM'h…3C3C repeated, base level hypervector (level 0).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous abort of the current sample.
- feat_valid, input, 1, feature available.
- feat_ready, output, 1, feature accepted when feat_valid && feat_ready.
- feat_value, input, LVL_DW (FEAT_DW with LVL_QUANT_EN), feature level.
- hv_valid, output, 1, output hypervectors valid.
- hv_ready, input, 1, downstream accepts.
- im_value, output, DIM, level hypervector.
- im_pos, output, DIM, position hypervector.
- hv_last, output, 1, output is element SMP_SIZE-1 of the sample.
- elem_idx, output, ELEM_DW, index of the element currently presented.
- smp_cnt, output, SMP_CNT_DW, completed samples (wraps).

Behaviour:
- Reset: all outputs 0; hv_valid=0, hv_last=0, elem_idx=0, smp_cnt=0; internal pos_reg=SEED_POS; feat_ready=1 after reset is released.
- Output stage is a single register; feat_ready = !hv_valid || hv_ready (combinational, no skid buffer).
- Latency: 1 cycle from input handshake to hv_valid. Full throughput of 1 element/cycle while hv_ready=1.
- Output state machine:
  - EMPTY → FULL on input handshake.
  - FULL → FULL on simultaneous output and input handshakes.
  - FULL → EMPTY on output handshake without input handshake.
  - Outputs are held stable while hv_valid && !hv_ready.
- Level HV, registered on input handshake: bit d = SEED_LVL[d] ^ (d < v*STEP), with STEP = DIM/(2*LEVELS) and v = feat_value.
  - Level 0 equals SEED_LVL.
  - Level LEVELS-1 differs from SEED_LVL in (LEVELS-1)*STEP bits.
- Position HV: im_pos takes pos_reg on input handshake; pos_reg then rotates left by 1, so element i = SEED_POS rotated left by i.
- Element counter advances on each input handshake.
  - At index SMP_SIZE-1 the registered hv_last=1.
  - Counter and pos_reg reload 0 and SEED_POS.
- smp_cnt increments by 1 on an output handshake with hv_last=1; it wraps modulo 2^SMP_CNT_DW.
- flush, synchronous, one cycle:
  - Clears hv_valid and hv_last, resets the element counter and pos_reg, and leaves smp_cnt unchanged.
  - flush beats a simultaneous input or output handshake: neither is counted and feat_ready is forced to 0 that cycle.
- Asynchronous reset mid-sample discards all state; the next element is element 0.
- feat_value is sampled only on the handshake; a value change while !feat_ready has no effect.

Optional Feature:
- Macro: HVGEN_LVL_QUANT_EN.
- Defined: adds parameter FEAT_DW (default 8), and feat_value is FEAT_DW wide.
  - Level = feat_value >> (FEAT_DW-LVL_DW), i.e. truncation, no rounding.
  - Requires FEAT_DW >= LVL_DW.
- Undefined: feat_value is LVL_DW wide and is used directly as the level.

Test Plan:
- Reset then 64 back-to-back features, all value 0, with hv_ready=1 → hv_valid rises 1 cycle after the first handshake. Every im_value == SEED_LVL. Element i im_pos == SEED_POS rotl i. hv_last only on element 63; smp_cnt=1.
- Single feature value 15, DIM=256/LVL_DW=4 → im_value bits [119:0] inverted vs SEED_LVL and bits [255:120] equal; value 1 → only bits [7:0] inverted.
- hv_ready held 0 for 5 cycles with feat_valid=1 → first element is held stable and feat_ready=0 throughout. Release → elements 0,1,2 appear on consecutive cycles with no drop or duplicate.
- Two full samples, with random hv_ready stalls covering 30% of cycles → 128 elements in order; element 64 im_pos == SEED_POS again; smp_cnt=2.
- flush at element 10 while hv_valid=1 and hv_ready=1 → output dropped and smp_cnt unchanged. Next element has elem_idx=0 and im_pos==SEED_POS.
- HVGEN_LVL_QUANT_EN with FEAT_DW=8: feat_value 8'hF3 → level 15; 8'h0F → level 0; 8'h10 → level 1 (bits [7:0] inverted).

Source files
------------

// File: rtl/hv_stream_gen.sv
// Hypervector stream generator: turns quantized features into level/position HV pairs for the HDC encoder.
// Optional macro HVGEN_LVL_QUANT_EN widens feat_value to FEAT_DW and truncates it to the level index.
module hv_stream_gen #(
    parameter int unsigned    DIM        = 256,
    parameter int unsigned    LVL_DW     = 4,
    parameter int unsigned    SMP_SIZE   = 64,
    parameter int unsigned    ELEM_DW    = 6,
    parameter int unsigned    SMP_CNT_DW = 16,
`ifdef HVGEN_LVL_QUANT_EN
    parameter int unsigned    FEAT_DW    = 8,
`endif
    parameter logic [DIM-1:0] SEED_POS   = {(DIM/16){16'hA5A5}},
    parameter logic [DIM-1:0] SEED_LVL   = {(DIM/16){16'h3C3C}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  feat_valid,
    output logic                  feat_ready,
`ifdef HVGEN_LVL_QUANT_EN
    input  logic [FEAT_DW-1:0]    feat_value,
`else
    input  logic [LVL_DW-1:0]     feat_value,
`endif
    output logic                  hv_valid,
    input  logic                  hv_ready,
    output logic [DIM-1:0]        im_value,
    output logic [DIM-1:0]        im_pos,
    output logic                  hv_last,
    output logic [ELEM_DW-1:0]    elem_idx,
    output logic [SMP_CNT_DW-1:0] smp_cnt
);

    localparam int unsigned LEVELS = 1 << LVL_DW;
    localparam int unsigned STEP   = DIM / (2 * LEVELS);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic                 in_hs;
    logic                 out_hs;
    logic                 smp_inc;
    logic                 last_c;
    logic [LVL_DW-1:0]    level_c;
    logic [DIM-1:0]       lvl_hv_c;
    int unsigned          flip_cnt;
    logic [ELEM_DW-1:0]   cnt_q;
    logic [DIM-1:0]       pos_q;

    // Output-stage occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush always empties the stage; otherwise track fill/drain handshakes
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (in_hs) state_d = ST_FULL;
                ST_FULL:  if (out_hs && !in_hs) state_d = ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Handshake qualification; flush suppresses both sides for that cycle
    always_comb begin
        feat_ready = 1'b0;
        in_hs      = 1'b0;
        out_hs     = 1'b0;
        smp_inc    = 1'b0;
        feat_ready = !flush && ((state_q == ST_EMPTY) || hv_ready);
        in_hs      = feat_valid && feat_ready;
        out_hs     = !flush && (state_q == ST_FULL) && hv_ready;
        smp_inc    = out_hs && hv_last;
    end

    assign hv_valid = (state_q == ST_FULL);
    assign last_c   = (cnt_q == ELEM_DW'(SMP_SIZE - 1));

`ifdef HVGEN_LVL_QUANT_EN
    assign level_c = LVL_DW'(feat_value >> (FEAT_DW - LVL_DW));
`else
    assign level_c = feat_value;
`endif

    // Level HV: flip the lowest level*STEP bits of the level-0 seed
    always_comb begin
        flip_cnt = 32'(level_c) * STEP;
        for (int unsigned d = 0; d < DIM; d++) begin
            lvl_hv_c[d] = SEED_LVL[d] ^ (d < flip_cnt);
        end
    end

    // Output payload register, loaded on input handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_value <= '0;
            im_pos   <= '0;
            hv_last  <= 1'b0;
            elem_idx <= '0;
        end else if (flush) begin
            hv_last  <= 1'b0;
            elem_idx <= '0;
        end else if (in_hs) begin
            im_value <= lvl_hv_c;
            im_pos   <= pos_q;
            hv_last  <= last_c;
            elem_idx <= cnt_q;
        end else if (out_hs) begin
            hv_last  <= 1'b0;
        end
    end

    // Element counter and rotating position HV; both rewind at sample end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pos_q <= SEED_POS;
        end else if (flush) begin
            cnt_q <= '0;
            pos_q <= SEED_POS;
        end else if (in_hs) begin
            if (last_c) begin
                cnt_q <= '0;
                pos_q <= SEED_POS;
            end else begin
                cnt_q <= cnt_q + ELEM_DW'(1);
                pos_q <= {pos_q[DIM-2:0], pos_q[DIM-1]};
            end
        end
    end

    // Completed-sample counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt <= '0;
        end else if (smp_inc) begin
            smp_cnt <= smp_cnt + SMP_CNT_DW'(1);
        end
    end

endmodule

// File: tb/tb_hv_stream_gen.sv
// Self-checking bench for hv_stream_gen: scoreboard of expected HV pairs plus per-scenario checks.
module tb_hv_stream_gen;

    localparam int unsigned DIM        = 256;
    localparam int unsigned LVL_DW     = 4;
    localparam int unsigned SMP_SIZE   = 64;
    localparam int unsigned ELEM_DW    = 6;
    localparam int unsigned SMP_CNT_DW = 16;
`ifdef HVGEN_LVL_QUANT_EN
    localparam int unsigned FW         = 8;
`else
    localparam int unsigned FW         = LVL_DW;
`endif
    localparam int unsigned STEP       = DIM / (2 * (1 << LVL_DW));
    localparam logic [DIM-1:0] SEED_POS = {16{16'hA5A5}};
    localparam logic [DIM-1:0] SEED_LVL = {16{16'h3C3C}};

    typedef struct packed {
        logic [DIM-1:0]     val;
        logic [DIM-1:0]     pos;
        logic               last;
        logic [ELEM_DW-1:0] idx;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic                  feat_valid;
    logic                  feat_ready;
    logic [FW-1:0]         feat_value;
    logic                  hv_valid;
    logic                  hv_ready;
    logic [DIM-1:0]        im_value;
    logic [DIM-1:0]        im_pos;
    logic                  hv_last;
    logic [ELEM_DW-1:0]    elem_idx;
    logic [SMP_CNT_DW-1:0] smp_cnt;

    exp_t                  sb[$];
    int unsigned           m_idx;
    logic [SMP_CNT_DW-1:0] exp_smp;
    int unsigned           n_out;
    int unsigned           n_checks;
    int unsigned           n_fail;
    logic                  rand_mode;
    logic [DIM-1:0]        seed_l;

    hv_stream_gen #(
        .DIM        (DIM),
        .LVL_DW     (LVL_DW),
        .SMP_SIZE   (SMP_SIZE),
        .ELEM_DW    (ELEM_DW),
        .SMP_CNT_DW (SMP_CNT_DW),
        .SEED_POS   (SEED_POS),
        .SEED_LVL   (SEED_LVL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .feat_value (feat_value),
        .hv_valid   (hv_valid),
        .hv_ready   (hv_ready),
        .im_value   (im_value),
        .im_pos     (im_pos),
        .hv_last    (hv_last),
        .elem_idx   (elem_idx),
        .smp_cnt    (smp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DIM-1:0] exp_val(input logic [FW-1:0] v);
        int unsigned    k;
        logic [DIM-1:0] ones;
        k    = 32'(v >> (FW - LVL_DW)) * STEP;
        ones = '1;
        if (k == 0) return SEED_LVL;
        return SEED_LVL ^ (ones >> (DIM - k));
    endfunction

    function automatic logic [DIM-1:0] exp_pos(input int unsigned k);
        if (k == 0) return SEED_POS;
        return (SEED_POS << k) | (SEED_POS >> (DIM - k));
    endfunction

    // Scoreboard: compare presented output on handshake, then record the accepted input
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            m_idx   = 0;
            exp_smp = '0;
        end else if (flush) begin
            sb.delete();
            m_idx = 0;
        end else begin
            n_checks++;
            if (smp_cnt !== exp_smp) begin
                n_fail++;
                $display("FAIL smp_cnt: got %0d expected %0d", smp_cnt, exp_smp);
            end
            if (hv_valid && hv_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: got output idx %0d expected no output", elem_idx);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    if (im_value !== e.val) begin
                        n_fail++;
                        $display("FAIL im_value[%0d]: got %h expected %h", e.idx, im_value, e.val);
                    end
                    n_checks++;
                    if (im_pos !== e.pos) begin
                        n_fail++;
                        $display("FAIL im_pos[%0d]: got %h expected %h", e.idx, im_pos, e.pos);
                    end
                    n_checks++;
                    if ({hv_last, elem_idx} !== {e.last, e.idx}) begin
                        n_fail++;
                        $display("FAIL last_idx: got last=%0d idx=%0d expected last=%0d idx=%0d",
                                 hv_last, elem_idx, e.last, e.idx);
                    end
                    if (e.last) exp_smp = exp_smp + 1'b1;
                end
            end
            if (feat_valid && feat_ready) begin
                e.val  = exp_val(feat_value);
                e.pos  = exp_pos(m_idx);
                e.last = (m_idx == SMP_SIZE - 1);
                e.idx  = ELEM_DW'(m_idx);
                sb.push_back(e);
                m_idx = (m_idx == SMP_SIZE - 1) ? 0 : m_idx + 1;
            end
        end
    end

    // Random backpressure generator, active only when rand_mode is set
    always begin
        @(posedge clk);
        #1;
        if (rand_mode) hv_ready = ($urandom_range(0, 99) >= 30);
    end

    task automatic send(input logic [FW-1:0] v);
        int unsigned n;
        n          = 0;
        feat_valid = 1'b1;
        feat_value = v;
        @(negedge clk);
        while (!feat_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!feat_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got feat_ready=0 expected 1 within 1000 cycles");
        end
        @(posedge clk);
        #1;
        feat_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n          = 0;
        rand_mode  = 1'b0;
        feat_valid = 1'b0;
        hv_ready   = 1'b1;
        while ((hv_valid || sb.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            hv_ready = 1'b1;
            n++;
        end
        n_checks++;
        if (hv_valid || sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got hv_valid=%0d pending=%0d expected 0/0", hv_valid, sb.size());
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; feat_valid = 1'b0; feat_value = '0;
        hv_ready = 1'b1; rand_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({hv_valid, hv_last, elem_idx, smp_cnt} !== '0 || im_value !== '0 || im_pos !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0d last=%0d idx=%0d smp=%0d expected all 0",
                     hv_valid, hv_last, elem_idx, smp_cnt);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (feat_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %0d expected 1", feat_ready);
        end
    endtask

    task automatic test_sample_zero();
        int unsigned n0;
        n0 = n_out;
        n_checks++;
        if (hv_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_valid: got %0d expected 0", hv_valid);
        end
        send('0);
        n_checks++;
        if (hv_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: got hv_valid=%0d expected 1", hv_valid);
        end
        for (int i = 1; i < 64; i++) send('0);
        drain();
        n_checks++;
        if (n_out - n0 != 64 || smp_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL sample_zero: got outputs=%0d smp=%0d expected 64/1", n_out - n0, smp_cnt);
        end
    endtask

    task automatic test_level();
        seed_l = SEED_LVL;
        send(FW'(15));
        n_checks++;
        if (im_value[119:0] !== ~seed_l[119:0] || im_value[255:120] !== seed_l[255:120]) begin
            n_fail++;
            $display("FAIL level15: got %h expected low 120 bits inverted of %h", im_value, seed_l);
        end
        send(FW'(1));
        n_checks++;
        if (im_value[7:0] !== ~seed_l[7:0] || im_value[255:8] !== seed_l[255:8]) begin
            n_fail++;
            $display("FAIL level1: got %h expected low 8 bits inverted of %h", im_value, seed_l);
        end
        drain();
    endtask

`ifdef HVGEN_LVL_QUANT_EN
    task automatic test_quant();
        seed_l = SEED_LVL;
        send(8'hF3);
        n_checks++;
        if (im_value[119:0] !== ~seed_l[119:0] || im_value[255:120] !== seed_l[255:120]) begin
            n_fail++;
            $display("FAIL quant_f3: got %h expected level 15", im_value);
        end
        send(8'h0F);
        n_checks++;
        if (im_value !== seed_l) begin
            n_fail++;
            $display("FAIL quant_0f: got %h expected %h", im_value, seed_l);
        end
        send(8'h10);
        n_checks++;
        if (im_value[7:0] !== ~seed_l[7:0] || im_value[255:8] !== seed_l[255:8]) begin
            n_fail++;
            $display("FAIL quant_10: got %h expected level 1", im_value);
        end
        drain();
    endtask
`endif

    task automatic test_stall();
        logic [DIM-1:0] hold_v;
        logic [DIM-1:0] hold_p;
        hv_ready   = 1'b0;
        feat_valid = 1'b1;
        feat_value = FW'(3);
        @(posedge clk);
        #1;
        hold_v     = im_value;
        hold_p     = im_pos;
        feat_value = FW'(4);
        n_checks++;
        if (elem_idx !== '0 || im_pos !== SEED_POS) begin
            n_fail++;
            $display("FAIL stall_first: got idx=%0d pos=%h expected 0 and seed", elem_idx, im_pos);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (hv_valid !== 1'b1 || feat_ready !== 1'b0 || im_value !== hold_v || im_pos !== hold_p) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got valid=%0d ready=%0d expected 1/0 and stable data",
                         c, hv_valid, feat_ready);
            end
        end
        hv_ready = 1'b1;
        @(posedge clk);
        #1;
        feat_value = FW'(5);
        n_checks++;
        if (hv_valid !== 1'b1 || elem_idx !== ELEM_DW'(1)) begin
            n_fail++;
            $display("FAIL release_e1: got valid=%0d idx=%0d expected 1/1", hv_valid, elem_idx);
        end
        @(posedge clk);
        #1;
        feat_valid = 1'b0;
        n_checks++;
        if (hv_valid !== 1'b1 || elem_idx !== ELEM_DW'(2)) begin
            n_fail++;
            $display("FAIL release_e2: got valid=%0d idx=%0d expected 1/2", hv_valid, elem_idx);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) send(FW'(i));
        hv_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (hv_valid !== 1'b0 || elem_idx !== '0 || im_pos !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got valid=%0d idx=%0d expected 0/0", hv_valid, elem_idx);
        end
        rst_n    = 1'b1;
        hv_ready = 1'b1;
        @(posedge clk);
        #1;
        send(FW'(2));
        n_checks++;
        if (elem_idx !== '0 || im_pos !== SEED_POS || smp_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_next: got idx=%0d smp=%0d pos=%h expected 0/0/seed",
                     elem_idx, smp_cnt, im_pos);
        end
        drain();
        do_flush();
    endtask

    task automatic test_random_samples();
        int unsigned n0;
        n0        = n_out;
        rand_mode = 1'b1;
        for (int i = 0; i < 128; i++) send(FW'($urandom_range(0, (1 << FW) - 1)));
        drain();
        n_checks++;
        if (n_out - n0 != 128 || smp_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL two_samples: got outputs=%0d smp=%0d expected 128/2", n_out - n0, smp_cnt);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i <= 10; i++) send(FW'(i));
        flush      = 1'b1;
        hv_ready   = 1'b1;
        feat_valid = 1'b1;
        feat_value = FW'(7);
        #1;
        n_checks++;
        if (feat_ready !== 1'b0 || elem_idx !== ELEM_DW'(10)) begin
            n_fail++;
            $display("FAIL flush_ready: got ready=%0d idx=%0d expected 0/10", feat_ready, elem_idx);
        end
        @(posedge clk);
        #1;
        flush      = 1'b0;
        feat_valid = 1'b0;
        n_checks++;
        if (hv_valid !== 1'b0 || hv_last !== 1'b0 || smp_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL flush_drop: got valid=%0d last=%0d smp=%0d expected 0/0/2",
                     hv_valid, hv_last, smp_cnt);
        end
        send(FW'(9));
        n_checks++;
        if (elem_idx !== '0 || im_pos !== SEED_POS) begin
            n_fail++;
            $display("FAIL flush_next: got idx=%0d pos=%h expected 0 and seed", elem_idx, im_pos);
        end
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_out    = 0;
        m_idx    = 0;
        exp_smp  = '0;
        test_reset();
        test_sample_zero();
`ifdef HVGEN_LVL_QUANT_EN
        test_quant();
`else
        test_level();
`endif
        do_flush();
        test_stall();
        test_reset_mid();
        test_random_samples();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
